// File: rtl/mem_port.sv
// Memory interface unit: runs one request/acknowledge bus transaction per
// decoded memory microword and returns extended load data to the data path.
module mem_port #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ld,
  input  logic        mem_wr,
  input  logic [2:0]  mt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_is_busy,
  output logic [31:0] rdata,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam bit               TO_EN    = (TIMEOUT != 32'd0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2:0]         mt_r;
  logic [1:0]         off_r;
  logic               is_ld_r;
  logic               mem_err_r;
  logic [31:0]        rdata_r;
  logic               bus_req_r;
  logic               bus_we_r;
  logic [31:0]        bus_addr_r;
  logic [3:0]         bus_be_r;
  logic [31:0]        bus_wdata_r;
  logic               req_s;
  logic               legal_s;
  logic               busy_s;

  // Alignment rules per access size; unknown mt codes are never legal.
  function automatic logic acc_legal(input logic [2:0] t, input logic [1:0] a);
    case (t)
      3'd1, 3'd5: acc_legal = 1'b1;
      3'd2, 3'd6: acc_legal = ~a[0];
      3'd3:       acc_legal = (a == 2'b00);
      default:    acc_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] t, input logic [1:0] a);
    case (t)
      3'd1, 3'd5: lane_be = 4'b0001 << a;
      3'd2, 3'd6: lane_be = a[1] ? 4'b1100 : 4'b0011;
      3'd3:       lane_be = 4'b1111;
      default:    lane_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] t, input logic [31:0] d);
    case (t)
      3'd1, 3'd5: lane_wdata = {4{d[7:0]}};
      3'd2, 3'd6: lane_wdata = {2{d[15:0]}};
      3'd3:       lane_wdata = d;
      default:    lane_wdata = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] t, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (t)
      3'd1:    load_extract = {{24{b[7]}}, b};
      3'd5:    load_extract = {24'd0, b};
      3'd2:    load_extract = {{16{h[15]}}, h};
      3'd6:    load_extract = {16'd0, h};
      3'd3:    load_extract = d;
      default: load_extract = 32'd0;
    endcase
  endfunction

  // Request decode and the busy flag the microsequencer spins on.
  always_comb begin
    req_s   = mem_ld | mem_wr;
    legal_s = acc_legal(mt, addr[1:0]) & ~(mem_ld & mem_wr);
    busy_s  = 1'b0;
    case (state_r)
      ST_IDLE: busy_s = req_s;
      ST_REQ:  busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Transaction FSM with all bus-side and result outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      mt_r        <= 3'd0;
      off_r       <= 2'd0;
      is_ld_r     <= 1'b0;
      mem_err_r   <= 1'b0;
      rdata_r     <= 32'd0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_be_r    <= 4'd0;
      bus_wdata_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          mem_err_r <= 1'b0;
          if (req_s) begin
            mt_r    <= mt;
            off_r   <= addr[1:0];
            is_ld_r <= mem_ld;
            if (legal_s) begin
              bus_req_r   <= 1'b1;
              bus_we_r    <= mem_wr;
              bus_addr_r  <= {addr[31:2], 2'b00};
              bus_be_r    <= lane_be(mt, addr[1:0]);
              bus_wdata_r <= mem_wr ? lane_wdata(mt, wdata) : 32'd0;
              cnt_r       <= {CNT_W{1'b0}};
              state_r     <= ST_REQ;
            end else begin
              mem_err_r <= 1'b1;
              state_r   <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            bus_req_r <= 1'b0;
            bus_we_r  <= 1'b0;
            bus_be_r  <= 4'd0;
            if (is_ld_r) begin
              rdata_r <= load_extract(mt_r, off_r, bus_rdata);
            end else begin
              rdata_r <= rdata_r;
            end
            state_r <= ST_DONE;
          end else if (TO_EN && (cnt_r == CNT_LAST)) begin
            bus_req_r <= 1'b0;
            bus_we_r  <= 1'b0;
            bus_be_r  <= 4'd0;
            mem_err_r <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Any request still visible here is the old microword; drop it.
          mem_err_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          mem_err_r <= 1'b0;
          bus_req_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_is_busy = busy_s;
  assign rdata       = rdata_r;
  assign mem_err     = mem_err_r;
  assign bus_req     = bus_req_r;
  assign bus_we      = bus_we_r;
  assign bus_addr    = bus_addr_r;
  assign bus_be      = bus_be_r;
  assign bus_wdata   = bus_wdata_r;

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: expected completions are queued when a request
// is driven and compared when the DUT reaches its completion cycle.
module tb_mem_port;

  logic        clk;
  logic        reset;
  logic        mem_ld;
  logic        mem_wr;
  logic [2:0]  mt;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_is_busy;
  logic [31:0] rdata;
  logic        mem_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  mem_port #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .mem_ld(mem_ld), .mem_wr(mem_wr), .mt(mt),
    .addr(addr), .wdata(wdata), .mem_is_busy(mem_is_busy), .rdata(rdata),
    .mem_err(mem_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drives one request and follows it to its completion cycle. ack_after is the
  // REQ cycle number on which bus_ack is raised (0 = never). Ends in the DONE
  // cycle with the request still held.
  task automatic run(input string tag, input logic ld, input logic wr, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] d, input int ack_after,
                     input logic [31:0] rd_in, input int exp_reqs, input logic exp_we,
                     input logic [31:0] exp_addr, input logic [3:0] exp_be,
                     input logic [31:0] exp_wd, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    exp_t got;
    int   reqs;
    logic done;
    mem_ld = ld; mem_wr = wr; mt = t; addr = a; wdata = d;
    e.rd = exp_rd; e.err = exp_err;
    sb.push_back(e);
    #1;
    check({tag, "_busy_c0"}, 32'(mem_is_busy), 32'd1);
    reqs = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(posedge clk); #1;
      if (!mem_is_busy) begin
        done = 1'b1;
      end else begin
        reqs++;
        check({tag, "_bus_req"},   32'(bus_req), 32'd1);
        check({tag, "_bus_we"},    32'(bus_we), 32'(exp_we));
        check({tag, "_bus_addr"},  bus_addr, exp_addr);
        check({tag, "_bus_be"},    32'(bus_be), 32'(exp_be));
        check({tag, "_bus_wdata"}, bus_wdata, exp_wd);
        check({tag, "_err_in_req"}, 32'(mem_err), 32'd0);
        if (reqs == ack_after) begin
          bus_ack = 1'b1; bus_rdata = rd_in;
        end else begin
          bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
        end
      end
    end
    bus_ack = 1'b0;
    check({tag, "_completed"}, 32'(done), 32'd1);
    check({tag, "_req_cycles"}, 32'(reqs), 32'(exp_reqs));
    check({tag, "_bus_req_done"}, 32'(bus_req), 32'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check({tag, "_rdata"}, rdata, got.rd);
      check({tag, "_mem_err"}, 32'(mem_err), 32'(got.err));
    end
  endtask

  task automatic idle_step(input string tag);
    mem_ld = 1'b0; mem_wr = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle_err"}, 32'(mem_err), 32'd0);
    check({tag, "_idle_req"}, 32'(bus_req), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; mem_ld = 1'b0; mem_wr = 1'b0; mt = 3'd0; addr = 32'd0; wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_busy", 32'(mem_is_busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run("ldw", 1'b1, 1'b0, 3'd3, 32'h100, 32'd0, 1, 32'hDEADBEEF, 1, 1'b0,
        32'h100, 4'b1111, 32'd0, 32'hDEADBEEF, 1'b0);
    idle_step("ldw");
    run("ldb", 1'b1, 1'b0, 3'd1, 32'h103, 32'd0, 1, 32'h80112233, 1, 1'b0,
        32'h100, 4'b1000, 32'd0, 32'hFFFFFF80, 1'b0);
    idle_step("ldb");
    run("ldbu", 1'b1, 1'b0, 3'd5, 32'h103, 32'd0, 1, 32'h80112233, 1, 1'b0,
        32'h100, 4'b1000, 32'd0, 32'h00000080, 1'b0);
    idle_step("ldbu");
    run("sth", 1'b0, 1'b1, 3'd2, 32'h202, 32'h0000ABCD, 3, 32'hFFFF_FFFF, 3, 1'b1,
        32'h200, 4'b1100, 32'hABCDABCD, 32'h00000080, 1'b0);
    idle_step("sth");
    run("misal", 1'b1, 1'b0, 3'd3, 32'h101, 32'd0, 1, 32'd0, 0, 1'b0,
        32'd0, 4'd0, 32'd0, 32'h00000080, 1'b1);
    idle_step("misal");
    run("mt7", 1'b1, 1'b0, 3'd7, 32'h100, 32'd0, 1, 32'd0, 0, 1'b0,
        32'd0, 4'd0, 32'd0, 32'h00000080, 1'b1);
    idle_step("mt7");
    run("ldwr", 1'b1, 1'b1, 3'd3, 32'h100, 32'd0, 1, 32'd0, 0, 1'b0,
        32'd0, 4'd0, 32'd0, 32'h00000080, 1'b1);
    idle_step("ldwr");
    run("tmo", 1'b1, 1'b0, 3'd3, 32'h104, 32'd0, 0, 32'd0, 4, 1'b0,
        32'h104, 4'b1111, 32'd0, 32'h00000080, 1'b1);
    // Request held through DONE: the following IDLE cycle must show no bus cycle.
    @(posedge clk); #1;
    check("b2b_no_second_req", 32'(bus_req), 32'd0);
    check("b2b_err_cleared", 32'(mem_err), 32'd0);
    run("ldhu", 1'b1, 1'b0, 3'd6, 32'h106, 32'd0, 2, 32'h12348765, 2, 1'b0,
        32'h104, 4'b1100, 32'd0, 32'h00001234, 1'b0);
    idle_step("ldhu");
    run("ldh", 1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 1, 32'h00008001, 1, 1'b0,
        32'h100, 4'b0011, 32'd0, 32'hFFFF8001, 1'b0);
    idle_step("ldh");
    run("stb", 1'b0, 1'b1, 3'd1, 32'h301, 32'h123456A5, 1, 32'd0, 1, 1'b1,
        32'h300, 4'b0010, 32'hA5A5A5A5, 32'hFFFF8001, 1'b0);
    idle_step("stb");

    // Reset while REQ is outstanding.
    mem_ld = 1'b1; mt = 3'd3; addr = 32'h400;
    @(posedge clk); #1;
    check("mid_req_up", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_bus_req", 32'(bus_req), 32'd0);
    check("mid_rst_bus_addr", bus_addr, 32'd0);
    check("mid_rst_bus_be", 32'(bus_be), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_err", 32'(mem_err), 32'd0);
    mem_ld = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_busy", 32'(mem_is_busy), 32'd0);
    @(posedge clk); #1;
    run("ldw2", 1'b1, 1'b0, 3'd3, 32'h400, 32'd0, 1, 32'h0BADF00D, 1, 1'b0,
        32'h400, 4'b1111, 32'd0, 32'h0BADF00D, 1'b0);
    idle_step("ldw2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port.md
Name: mem_port

Overview:
- Memory interface unit directly downstream of the microcoded control path.
- Consumes the decoded memory fields mem_ld, mem_wr and mt, plus the address and store data from the data path.
- Runs a single-outstanding request/acknowledge transaction on the memory bus.
- Returns sign- or zero-extended load data and drives mem_is_busy, on which the microsequencer's spin branch (UBR_S) holds the uPC.

Parameters:
- TIMEOUT, 255: max cycles in REQ awaiting bus_ack before abort with error; 0 disables timeout.
- CNT_W, 8: width of the timeout counter; TIMEOUT must fit in CNT_W bits.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- mem_ld  in  1  load request, held by control path while spinning
- mem_wr  in  1  store request, held by control path while spinning
- mt  in  3  access type: 1=B signed, 2=H signed, 3=W, 5=BU, 6=HU; others illegal
- addr  in  32  byte address from data path
- wdata  in  32  store data, right-justified
- mem_is_busy  out  1  combinational busy to control path
- rdata  out  32  registered, extended load data
- mem_err  out  1  one-cycle pulse in DONE when the access failed
- bus_req  out  1  registered bus request
- bus_we  out  1  registered write enable
- bus_addr  out  32  registered word address, addr[1:0] forced to 0
- bus_be  out  4  registered byte enables
- bus_wdata  out  32  registered lane-replicated store data
- bus_ack  in  1  memory completion, valid only while bus_req=1
- bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
- Reset (async) values: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rdata=0, mem_err=0, counter=0.
- req = mem_ld | mem_wr.
- mem_is_busy = (state==IDLE & req) | (state==REQ). It is 0 in DONE and in IDLE without req.
- IDLE:
  - On req, decode the access and latch mt and addr[1:0].
  - Illegal access (illegal mt, mem_ld&mem_wr, H with addr[0]=1, W with addr[1:0]!=0): go to DONE with err flag set, no bus cycle.
  - Legal access: load bus_* registers, set bus_req=1, clear counter, go to REQ.
- REQ:
  - bus_req is held and bus_* outputs are stable.
  - On bus_ack: drop bus_req/bus_we/bus_be. If load, capture extracted bus_rdata into rdata. Go to DONE.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: drop bus_req, set err flag, leave rdata unchanged, go to DONE.
  - Else counter+1.
- DONE:
  - mem_is_busy=0, so the control path advances this cycle.
  - mem_err equals the err flag; clear the flag.
  - Go to IDLE unconditionally. A request present in DONE belongs to the held old microword and is ignored.
  - A new request is accepted the following cycle.
- Store lanes:
  - B: bus_wdata={4{wdata[7:0]}}, bus_be=4'b0001<<addr[1:0].
  - H: bus_wdata={2{wdata[15:0]}}, bus_be=addr[1]?1100:0011.
  - W: bus_wdata=wdata, bus_be=1111.
- Load extract (using latched addr[1:0]):
  - B/BU select byte addr[1:0].
  - H/HU select half addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - For loads bus_be is set as for stores; bus_wdata=0.
- Minimum legal latency: request cycle c0 (busy=1), c1 REQ with ack, c2 DONE (busy=0). rdata is valid from c2 onward until the next completed load.
- bus_ack in IDLE/DONE is ignored.
- rdata holds its value across stores and errors.
- Reset mid-REQ: bus_req drops asynchronously; no completion or error is reported.

Test Plan:
- Word load, addr=0x100, mt=3, bus_ack on first REQ cycle with bus_rdata=0xDEADBEEF -> busy for c0,c1; bus_addr=0x100, bus_be=1111; at c2 busy=0, rdata=0xDEADBEEF, mem_err=0.
- Signed/unsigned byte loads, addr=0x103, bus_rdata=0x80112233 -> mt=1 gives rdata=0xFFFFFF80; mt=5 gives 0x00000080; bus_be=1000 both times.
- Halfword store, addr=0x202, wdata=0x0000ABCD, mt=2, ack after 3 REQ cycles -> bus_we=1, bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD held stable for all 3 cycles; busy deasserts in DONE; rdata unchanged.
- Misaligned word load, addr=0x101 -> bus_req never asserts; DONE next cycle with mem_err=1 for one cycle. Same result for mt=7 and for mem_ld=mem_wr=1.
- Timeout with TIMEOUT=4, no ack -> bus_req high exactly 4 cycles, then DONE with mem_err=1. Back-to-back request held through DONE produces no second transaction; a new request the cycle after DONE starts one.
- Reset asserted mid-REQ, then released -> bus_req=0 immediately, all outputs at reset values, state=IDLE; the next load completes normally.
